sound_mixer_seq: RTL and testbench



---
 rtl/sound_mixer_seq.sv | 141 ++++++++++++++
 tb/tb_sound_mixer_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_mixer_seq.sv
// Time-multiplexed stereo mixer: snapshots channel levels on sample_tick, accumulates
// one channel per cycle, applies master volume and offers the sample over valid/ready.
module sound_mixer_seq #(
  parameter int NUM_CH  = 4,
  parameter int LEVEL_W = 4,
  parameter int VOL_W   = 3,
  parameter int OUT_W   = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_tick,
  input  logic                      sound_enable,
  input  logic [NUM_CH*LEVEL_W-1:0] ch_level,
  input  logic [NUM_CH-1:0]         pan_left,
  input  logic [NUM_CH-1:0]         pan_right,
  input  logic [VOL_W-1:0]          vol_left,
  input  logic [VOL_W-1:0]          vol_right,
  output logic [OUT_W-1:0]          out_left,
  output logic [OUT_W-1:0]          out_right,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overrun,
  input  logic                      overrun_clr
);

  localparam int SUM_W  = LEVEL_W + $clog2(NUM_CH);
  localparam int PROD_W = SUM_W + VOL_W;
  localparam int PAD_W  = OUT_W - 1 - PROD_W;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, HOLD} state_t;

  state_t state, state_next;

  logic [LEVEL_W-1:0] level_q [NUM_CH];
  logic [NUM_CH-1:0]  pan_l_q, pan_r_q;
  logic [VOL_W-1:0]   vol_l_q, vol_r_q;
  logic               enable_q;

  logic [IDX_W-1:0] idx;
  logic [SUM_W-1:0] acc_l, acc_r;

  logic take_tick, drop_tick, handshake;
  logic [SUM_W-1:0]  add_l, add_r;
  logic [VOL_W:0]    gain_l, gain_r;
  logic [PROD_W-1:0] prod_l, prod_r;

  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    take_tick  = 1'b0;
    drop_tick  = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick) begin
          take_tick  = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        drop_tick = sample_tick;
        if (idx == LAST_IDX) state_next = SCALE;
      end
      SCALE: begin
        drop_tick  = sample_tick;
        state_next = HOLD;
      end
      HOLD: begin
        if (handshake) begin
          take_tick  = sample_tick;
          state_next = sample_tick ? ACCUM : IDLE;
        end else begin
          drop_tick = sample_tick;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: current channel contribution and volume-scaled products.
  always_comb begin
    add_l  = pan_l_q[idx] ? SUM_W'(level_q[idx]) : '0;
    add_r  = pan_r_q[idx] ? SUM_W'(level_q[idx]) : '0;
    gain_l = {1'b0, vol_l_q} + {{VOL_W{1'b0}}, 1'b1};
    gain_r = {1'b0, vol_r_q} + {{VOL_W{1'b0}}, 1'b1};
    prod_l = enable_q ? PROD_W'(acc_l) * PROD_W'(gain_l) : '0;
    prod_r = enable_q ? PROD_W'(acc_r) * PROD_W'(gain_r) : '0;
  end

  // NOTE: snapshot registers are only read after a tick has loaded them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (take_tick) begin
      for (int i = 0; i < NUM_CH; i++) level_q[i] <= ch_level[i*LEVEL_W +: LEVEL_W];
      pan_l_q  <= pan_left;
      pan_r_q  <= pan_right;
      vol_l_q  <= vol_left;
      vol_r_q  <= vol_right;
      enable_q <= sound_enable;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (take_tick) begin
        idx   <= '0;
        acc_l <= '0;
        acc_r <= '0;
      end else if (state == ACCUM) begin
        idx   <= idx + IDX_W'(1);
        acc_l <= acc_l + add_l;
        acc_r <= acc_r + add_r;
      end
      if (state == SCALE) begin
        out_left  <= OUT_W'(prod_l) << PAD_W;
        out_right <= OUT_W'(prod_r) << PAD_W;
      end
      out_valid <= (state_next == HOLD);
      // A dropped tick outranks a simultaneous clear.
      if (drop_tick)        overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sound_mixer_seq.sv
// Self-checking bench for sound_mixer_seq: directed scenarios plus randomized samples
// compared against an arithmetic model of the mix.
module tb_sound_mixer_seq;

  localparam int NUM_CH  = 4;
  localparam int LEVEL_W = 4;
  localparam int VOL_W   = 3;
  localparam int OUT_W   = 20;
  localparam int SHIFT   = OUT_W - 1 - (LEVEL_W + $clog2(NUM_CH) + VOL_W);
  localparam int LAT     = NUM_CH + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst = 1'b1;
  logic                      sample_tick = 1'b0;
  logic                      sound_enable = 1'b0;
  logic [NUM_CH*LEVEL_W-1:0] ch_level = '0;
  logic [NUM_CH-1:0]         pan_left = '0, pan_right = '0;
  logic [VOL_W-1:0]          vol_left = '0, vol_right = '0;
  logic [OUT_W-1:0]          out_left, out_right;
  logic                      out_valid, overrun;
  logic                      out_ready = 1'b0;
  logic                      overrun_clr = 1'b0;

  sound_mixer_seq dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .sound_enable(sound_enable),
    .ch_level(ch_level), .pan_left(pan_left), .pan_right(pan_right),
    .vol_left(vol_left), .vol_right(vol_right),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  // Parameter-sweep instances: 3 and 8 channels, all levels max, volume 7.
  logic        sw_tick = 1'b0;
  logic [11:0] lv3 = '1;
  logic [31:0] lv8 = '1;
  logic [2:0]  pn3 = '1;
  logic [7:0]  pn8 = '1;
  logic [2:0]  vmax = 3'd7;
  logic [OUT_W-1:0] o3l, o3r, o8l, o8r;
  logic        v3, v8, ov3, ov8;

  sound_mixer_seq #(.NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .sample_tick(sw_tick), .sound_enable(1'b1),
    .ch_level(lv3), .pan_left(pn3), .pan_right(pn3), .vol_left(vmax), .vol_right(vmax),
    .out_left(o3l), .out_right(o3r), .out_valid(v3), .out_ready(1'b0),
    .overrun(ov3), .overrun_clr(1'b0)
  );

  sound_mixer_seq #(.NUM_CH(8)) dut8 (
    .clk(clk), .rst(rst), .sample_tick(sw_tick), .sound_enable(1'b1),
    .ch_level(lv8), .pan_left(pn8), .pan_right(pn8), .vol_left(vmax), .vol_right(vmax),
    .out_left(o8l), .out_right(o8r), .out_valid(v8), .out_ready(1'b0),
    .overrun(ov8), .overrun_clr(1'b0)
  );

  int checks = 0;
  int failures = 0;
  logic [OUT_W-1:0] exp_l, exp_r;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mix model: sum of panned channel levels, times (volume+1), left-justified.
  function automatic logic [OUT_W-1:0] model(input logic [NUM_CH*LEVEL_W-1:0] lv,
                                             input logic [NUM_CH-1:0] pan,
                                             input logic [VOL_W-1:0] vol,
                                             input logic en);
    int sum = 0;
    for (int i = 0; i < NUM_CH; i++)
      if (pan[i]) sum += int'(lv[i*LEVEL_W +: LEVEL_W]);
    if (!en) return '0;
    return OUT_W'(sum * (int'(vol) + 1) * (1 << SHIFT));
  endfunction

  task automatic scramble_inputs();
    ch_level     = NUM_CH*LEVEL_W'($urandom);
    pan_left     = NUM_CH'($urandom);
    pan_right    = NUM_CH'($urandom);
    vol_left     = VOL_W'($urandom);
    vol_right    = VOL_W'($urandom);
    sound_enable = 1'($urandom);
  endtask

  task automatic apply_inputs(input logic [NUM_CH*LEVEL_W-1:0] lv, input logic [NUM_CH-1:0] pl,
                              input logic [NUM_CH-1:0] pr, input logic [VOL_W-1:0] vl,
                              input logic [VOL_W-1:0] vr, input logic en);
    ch_level = lv; pan_left = pl; pan_right = pr;
    vol_left = vl; vol_right = vr; sound_enable = en;
    exp_l = model(lv, pl, vl, en);
    exp_r = model(lv, pr, vr, en);
  endtask

  // Pulses a tick with the given inputs, then scrambles them to prove the snapshot.
  task automatic start_sample(input logic [NUM_CH*LEVEL_W-1:0] lv, input logic [NUM_CH-1:0] pl,
                              input logic [NUM_CH-1:0] pr, input logic [VOL_W-1:0] vl,
                              input logic [VOL_W-1:0] vr, input logic en);
    apply_inputs(lv, pl, pr, vl, vr, en);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    scramble_inputs();
  endtask

  // Waits (bounded) for out_valid after a tick step; checks latency and sample values.
  task automatic wait_valid(input string name);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
    end
    checks++;
    if (out_left !== exp_l) begin
      failures++;
      $display("FAIL %s out_left: got %h expected %h", name, out_left, exp_l);
    end
    checks++;
    if (out_right !== exp_r) begin
      failures++;
      $display("FAIL %s out_right: got %h expected %h", name, out_right, exp_r);
    end
  endtask

  task automatic accept(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s valid after handshake: got %b expected 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({out_left, out_right, out_valid, overrun} !== '0) begin
      failures++;
      $display("FAIL reset outputs: got l=%h r=%h v=%b o=%b expected all 0",
               out_left, out_right, out_valid, overrun);
    end
    rst = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset idle valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_full_scale();
    start_sample('1, '1, '1, 3'd7, 3'd7, 1'b1);
    wait_valid("full_scale");
    checks++;
    if (out_left !== 20'h78000 || out_right !== 20'h78000) begin
      failures++;
      $display("FAIL full_scale const: got l=%h r=%h expected 78000", out_left, out_right);
    end
    accept("full_scale");
  endtask

  task automatic test_pan_vol();
    start_sample({4'd4, 4'd3, 4'd2, 4'd1}, 4'b0101, 4'b1010, 3'd0, 3'd3, 1'b1);
    wait_valid("pan_vol");
    checks++;
    if (out_left !== 20'h01000 || out_right !== 20'h06000) begin
      failures++;
      $display("FAIL pan_vol const: got l=%h r=%h expected 01000/06000", out_left, out_right);
    end
    accept("pan_vol");
  endtask

  task automatic test_backpressure();
    int bad = 0;
    start_sample({4'd9, 4'd7, 4'd5, 4'd3}, 4'b1111, 4'b0011, 3'd5, 3'd2, 1'b1);
    wait_valid("backpressure");
    for (int i = 0; i < 10; i++) begin
      ch_level = NUM_CH*LEVEL_W'($urandom);
      step();
      if (out_valid !== 1'b1 || out_left !== exp_l || out_right !== exp_r) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure hold: %0d unstable cycles expected 0", bad);
    end
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1 || out_valid !== 1'b1 || out_left !== exp_l) begin
      failures++;
      $display("FAIL hold tick: got ovr=%b v=%b l=%h expected 1 1 %h",
               overrun, out_valid, out_left, exp_l);
    end
    sample_tick = 1'b1;
    overrun_clr = 1'b1;
    step();
    sample_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL set_wins overrun: got %b expected 1", overrun);
    end
    step();
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clr: got %b expected 0", overrun);
    end
    accept("backpressure");
    step();
    checks++;
    if (out_valid !== 1'b0 || out_left !== exp_l || out_right !== exp_r) begin
      failures++;
      $display("FAIL idle keep: got v=%b l=%h r=%h expected 0 %h %h",
               out_valid, out_left, out_right, exp_l, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    start_sample({4'd1, 4'd2, 4'd3, 4'd4}, 4'b1111, 4'b1111, 3'd1, 3'd1, 1'b1);
    wait_valid("b2b_first");
    apply_inputs({4'd15, 4'd0, 4'd8, 4'd6}, 4'b1001, 4'b0110, 3'd6, 3'd4, 1'b1);
    out_ready = 1'b1;
    sample_tick = 1'b1;
    step();
    out_ready = 1'b0;
    sample_tick = 1'b0;
    scramble_inputs();
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b accept: got v=%b ovr=%b expected 0 0", out_valid, overrun);
    end
    wait_valid("b2b_second");
    accept("b2b_second");
  endtask

  task automatic test_disable();
    start_sample('1, '1, '1, 3'd7, 3'd7, 1'b0);
    wait_valid("disable");
    accept("disable");
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    start_sample('1, '1, '1, 3'd7, 3'd7, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({out_left, out_right, out_valid, overrun} !== '0) begin
      failures++;
      $display("FAIL mid reset: got l=%h r=%h v=%b o=%b expected all 0",
               out_left, out_right, out_valid, overrun);
    end
    for (int i = 0; i < NUM_CH + 4; i++) begin
      step();
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mid reset aborted: got %0d valid cycles expected 0", seen);
    end
    start_sample({4'd2, 4'd11, 4'd0, 4'd13}, 4'b1110, 4'b0111, 3'd3, 3'd6, 1'b1);
    wait_valid("after_reset");
    accept("after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      start_sample(NUM_CH*LEVEL_W'($urandom), NUM_CH'($urandom), NUM_CH'($urandom),
                   VOL_W'($urandom), VOL_W'($urandom), ($urandom_range(0, 3) != 0));
      wait_valid("random");
      repeat ($urandom_range(0, 3)) step();
      accept("random");
    end
  endtask

  task automatic test_sweep();
    int lat = 1, lat3 = 0, lat8 = 0;
    logic [OUT_W-1:0] e3, e8;
    e3 = OUT_W'(3 * 15 * 8 * (1 << (OUT_W - 1 - (4 + 2 + 3))));
    e8 = OUT_W'(8 * 15 * 8 * (1 << (OUT_W - 1 - (4 + 3 + 3))));
    sw_tick = 1'b1;
    step();
    sw_tick = 1'b0;
    while ((lat3 == 0 || lat8 == 0) && lat < 40) begin
      step();
      lat++;
      if (v3 && lat3 == 0) lat3 = lat;
      if (v8 && lat8 == 0) lat8 = lat;
    end
    checks++;
    if (lat3 != 5 || lat8 != 10) begin
      failures++;
      $display("FAIL sweep latency: got %0d/%0d expected 5/10", lat3, lat8);
    end
    checks++;
    if (o3l !== e3 || o3r !== e3) begin
      failures++;
      $display("FAIL sweep ch3: got l=%h r=%h expected %h", o3l, o3r, e3);
    end
    checks++;
    if (o8l !== e8 || o8r !== e8) begin
      failures++;
      $display("FAIL sweep ch8: got l=%h r=%h expected %h", o8l, o8r, e8);
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_pan_vol();
    test_backpressure();
    test_back_to_back();
    test_disable();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
